vmx_array_ctrl: RTL and testbench

//  Job sequencer for a linear chain of N_PE vmx_pe_16_8 processing elements.

---
 rtl/vmx_array_ctrl_if.sv | 30 +++
 rtl/vmx_array_ctrl.sv | 162 ++++++++++++++++
 tb/tb_vmx_array_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmx_array_ctrl_if.sv
// Stream bundle between the DMA buffers and the PE array sequencer.
// Weight and input streams flow in, results flow out without backpressure.
interface vmx_array_ctrl_if #(
  parameter int VEC_W = 16,
  parameter int SUM_W = 32
) ();
  logic             w_valid;
  logic             w_ready;
  logic [VEC_W-1:0] w_data;
  logic             x_valid;
  logic             x_ready;
  logic [VEC_W-1:0] x_data;
  logic             res_valid;
  logic [SUM_W-1:0] res_data;
  logic             res_last;

  modport master (
    output w_valid, w_data,
    output x_valid, x_data,
    input  w_ready, x_ready,
    input  res_valid, res_data, res_last
  );

  modport slave (
    input  w_valid, w_data,
    input  x_valid, x_data,
    output w_ready, x_ready,
    output res_valid, res_data, res_last
  );
endinterface

// File: rtl/vmx_array_ctrl.sv
// Job sequencer for a chain of vmx_pe_16_8 PEs: tagged weight load,
// input streaming and result capture from the last PE.
module vmx_array_ctrl #(
  parameter int N_PE  = 4,
  parameter int VEC_W = 16,
  parameter int SUM_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_simd,
  input  logic [CNT_W-1:0] cfg_num_vec,
  output logic             busy,
  output logic             done,
  vmx_array_ctrl_if.slave  io,
  output logic             pe_simd_mode,
  output logic [7:0]       pe_load_ctrl,
  output logic [VEC_W-1:0] pe_data,
  output logic [SUM_W-1:0] pe_sum_in,
  input  logic [SUM_W-1:0] pe_sum_out
);

  localparam logic [5:0] W_LAST = 6'(N_PE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  state_t state;
  state_t state_n;

  logic             simd_q;
  logic [CNT_W-1:0] num_vec;
  logic [5:0]       w_idx;
  logic [CNT_W-1:0] vec_cnt;
  logic [N_PE:0]    vpipe;
  logic [N_PE:0]    lpipe;

  logic             w_hs;
  logic             x_hs;
  logic             accept;
  logic             w_last;
  logic             x_last;
  logic             pipe_empty;

  logic             busy_d;
  logic             done_d;
  logic             w_ready_d;
  logic             x_ready_d;
  logic             simd_n;
  logic             simd_d;
  logic [7:0]       ctrl_d;
  logic [VEC_W-1:0] data_d;

  assign w_hs       = io.w_valid & io.w_ready;
  assign x_hs       = io.x_valid & io.x_ready;
  assign accept     = (state == S_IDLE) & start & ~done;
  assign w_last     = w_hs & (w_idx == W_LAST);
  assign x_last     = x_hs & ((vec_cnt + CNT_W'(1)) == num_vec);
  assign pipe_empty = ~|vpipe;
  assign pe_sum_in  = '0;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (w_last)
          state_n = (num_vec == '0) ? S_DRAIN
                                    : S_COMPUTE;
      end
      S_COMPUTE: begin
        if (x_last) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (pipe_empty) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    busy_d    = (state_n != S_IDLE);
    done_d    = (state == S_DRAIN) &
                (state_n == S_IDLE);
    w_ready_d = (state_n == S_LOAD_W);
    x_ready_d = (state_n == S_COMPUTE);
    simd_n    = accept ? cfg_simd : simd_q;
    simd_d    = busy_d & simd_n;
    ctrl_d    = 8'h00;
    data_d    = '0;
    unique case (1'b1)
      w_hs: begin
        ctrl_d = {2'b10, w_idx};
        data_d = io.w_data;
      end
      x_hs: begin
        data_d = io.x_data;
      end
      default: ;
    endcase
  end

  // job config, counters, valid/last pipes and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      simd_q       <= 1'b0;
      num_vec      <= '0;
      w_idx        <= '0;
      vec_cnt      <= '0;
      vpipe        <= '0;
      lpipe        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      io.w_ready   <= 1'b0;
      io.x_ready   <= 1'b0;
      pe_simd_mode <= 1'b0;
      pe_load_ctrl <= 8'h00;
      pe_data      <= '0;
      io.res_valid <= 1'b0;
      io.res_data  <= '0;
      io.res_last  <= 1'b0;
    end else begin
      if (accept) begin
        simd_q  <= cfg_simd;
        num_vec <= cfg_num_vec;
        w_idx   <= '0;
        vec_cnt <= '0;
      end else begin
        if (w_hs) w_idx   <= w_idx + 6'd1;
        if (x_hs) vec_cnt <= vec_cnt + CNT_W'(1);
      end
      vpipe        <= {vpipe[N_PE-1:0], x_hs};
      lpipe        <= {lpipe[N_PE-1:0], x_last};
      busy         <= busy_d;
      done         <= done_d;
      io.w_ready   <= w_ready_d;
      io.x_ready   <= x_ready_d;
      pe_simd_mode <= simd_d;
      pe_load_ctrl <= ctrl_d;
      pe_data      <= data_d;
      io.res_valid <= vpipe[N_PE];
      io.res_last  <= vpipe[N_PE] & lpipe[N_PE];
      if (vpipe[N_PE]) io.res_data <= pe_sum_out;
    end
  end

endmodule

// File: tb/tb_vmx_array_ctrl.sv
// Bench for vmx_array_ctrl: behavioural PE chain plus a
// scoreboard of expected dot products per accepted input.
module tb_vmx_array_ctrl;

  localparam int N_PE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cfg_simd = 1'b0;
  logic [15:0] cfg_num_vec = '0;
  logic        busy;
  logic        done;
  logic        pe_simd_mode;
  logic [7:0]  pe_load_ctrl;
  logic [15:0] pe_data;
  logic [31:0] pe_sum_in;
  logic [31:0] pe_sum_out;

  vmx_array_ctrl_if #(.VEC_W(16), .SUM_W(32)) bus ();

  vmx_array_ctrl #(
    .N_PE(N_PE), .VEC_W(16), .SUM_W(32), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_simd(cfg_simd),
    .cfg_num_vec(cfg_num_vec),
    .busy(busy),
    .done(done),
    .io(bus.slave),
    .pe_simd_mode(pe_simd_mode),
    .pe_load_ctrl(pe_load_ctrl),
    .pe_data(pe_data),
    .pe_sum_in(pe_sum_in),
    .pe_sum_out(pe_sum_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, want);
    end
  endtask

  function automatic logic [31:0] mac(
    input logic s, input logic [15:0] w,
    input logic [15:0] d);
    int a, b, hi, lo;
    if (!s) begin
      a = int'($signed(w));
      b = int'($signed(d));
      return 32'(a * b);
    end
    hi = int'($signed(w[15:8])) * int'($signed(d[15:8]));
    lo = int'($signed(w[7:0])) * int'($signed(d[7:0]));
    return {hi[15:0], lo[15:0]};
  endfunction

  function automatic logic [31:0] add(
    input logic s, input logic [31:0] a,
    input logic [31:0] b);
    if (s) return {a[31:16] + b[31:16], a[15:0] + b[15:0]};
    return a + b;
  endfunction

  // behavioural PE chain: tag-matched weight load, registered MAC
  logic [15:0] c_d [N_PE];
  logic [7:0]  c_c [N_PE];
  logic [31:0] c_s [N_PE];
  logic [15:0] c_w [N_PE];
  logic [15:0] din;
  logic [7:0]  cin;
  logic [31:0] sin;

  always @(posedge clk) begin
    for (int i = 0; i < N_PE; i++) begin
      if (i == 0) begin
        din = pe_data; cin = pe_load_ctrl; sin = pe_sum_in;
      end else begin
        din = c_d[i-1]; cin = c_c[i-1]; sin = c_s[i-1];
      end
      if (cin[7] && cin[5:0] == 6'(i)) c_w[i] <= din;
      c_s[i] <= add(pe_simd_mode, sin,
                    mac(pe_simd_mode, c_w[i], din));
      c_d[i] <= din;
      c_c[i] <= cin;
    end
  end

  assign pe_sum_out = c_s[N_PE-1];

  // scoreboard state
  typedef struct {
    logic [31:0] d;
    logic        l;
    int          c;
  } sb_t;

  sb_t         q [$];
  logic [15:0] wmod [N_PE];
  logic [15:0] wset [N_PE];
  int          widx = 0;
  int          xcnt = 0;
  int          cyc = 0;
  int          cur_nv = 0;
  bit          cur_simd = 0;
  logic [7:0]  exp_ctrl = '0;
  logic [15:0] exp_pdata = '0;
  int          nres = 0;
  int          nlast = 0;
  logic [31:0] last_res = '0;
  bit          x_fix_en = 0;
  logic [15:0] x_fix = '0;

  function automatic logic [31:0] ref_dot(
    input logic s, input logic [15:0] x);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < N_PE; i++)
      acc = add(s, acc, mac(s, wmod[i], x));
    return acc;
  endfunction

  // observe handshakes on the active edge
  always @(posedge clk) begin
    sb_t e;
    cyc++;
    if (rst) begin
      q.delete();
      widx = 0; xcnt = 0;
      exp_ctrl = '0; exp_pdata = '0;
    end else begin
      exp_ctrl = '0; exp_pdata = '0;
      if (bus.w_valid && bus.w_ready) begin
        exp_ctrl = 8'h80 | 8'(widx);
        exp_pdata = bus.w_data;
        wmod[widx] = bus.w_data;
        widx = (widx == N_PE - 1) ? 0 : widx + 1;
      end else if (bus.x_valid && bus.x_ready) begin
        exp_pdata = bus.x_data;
        e.d = ref_dot(cur_simd, bus.x_data);
        e.l = (xcnt + 1 == cur_nv);
        e.c = cyc;
        q.push_back(e);
        xcnt = e.l ? 0 : xcnt + 1;
      end
    end
  end

  // check outputs mid-cycle
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      chk("pe_ctrl", pe_load_ctrl, exp_ctrl);
      chk("pe_data", pe_data, exp_pdata);
      chk("simd_mode", pe_simd_mode,
          busy ? cur_simd : 1'b0);
      if (bus.res_valid) begin
        nres++;
        if (bus.res_last) nlast++;
        last_res = bus.res_data;
        chk("res_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("res_data", bus.res_data, e.d);
          chk("res_last", bus.res_last, e.l);
          chk("res_lat", cyc - e.c, N_PE + 1);
        end
      end
    end
  end

  task automatic chk_zero(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_wrdy"}, bus.w_ready, 0);
    chk({p, "_xrdy"}, bus.x_ready, 0);
    chk({p, "_rv"}, bus.res_valid, 0);
    chk({p, "_rd"}, bus.res_data, 0);
    chk({p, "_rl"}, bus.res_last, 0);
    chk({p, "_simd"}, pe_simd_mode, 0);
    chk({p, "_ctrl"}, pe_load_ctrl, 0);
    chk({p, "_pdat"}, pe_data, 0);
    chk({p, "_sumin"}, pe_sum_in, 0);
  endtask

  task automatic run_job(input bit simd, input int nv,
                         input bit wgap, input int xmode,
                         input int abort_at, input bit b2b,
                         input bit busy_start);
    int  k, j, t, n0, l0, snap;
    bit  ph, got;
    n0 = nres; l0 = nlast;
    @(negedge clk);
    cfg_simd = simd; cfg_num_vec = 16'(nv);
    cur_simd = simd; cur_nv = nv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    k = 0; t = 0;
    while (k < N_PE && t < 500) begin
      @(negedge clk);
      t++;
      bus.w_valid = wgap ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.w_data = wset[k];
      if (busy_start && t == 2) begin
        start = 1'b1; cfg_simd = ~simd; cfg_num_vec = 16'd7;
      end else begin
        start = 1'b0;
      end
      if (bus.w_valid && bus.w_ready) k++;
    end
    chk("w_accepted", k, N_PE);
    j = 0; t = 0; ph = 1'b1;
    while (j < nv && t < 500) begin
      @(negedge clk);
      t++;
      bus.w_valid = 1'b0; start = 1'b0;
      if (abort_at >= 0 && j == abort_at) begin
        #2 rst = 1'b1;
        #1 chk_zero("abort");
        bus.x_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        snap = nres;
        repeat (12) @(negedge clk);
        chk("abort_nores", nres - snap, 0);
        chk("abort_busy", busy, 0);
        chk("abort_xrdy", bus.x_ready, 0);
        return;
      end
      case (xmode)
        0: bus.x_valid = 1'b1;
        1: begin bus.x_valid = ph; ph = ~ph; end
        default: bus.x_valid = 1'($urandom_range(0, 1));
      endcase
      bus.x_data = x_fix_en ? x_fix : 16'($urandom);
      if (bus.x_valid && bus.x_ready) j++;
    end
    chk("x_accepted", j, nv);
    t = 0; got = 0;
    while (!got && t < 200) begin
      @(negedge clk);
      t++;
      bus.w_valid = 1'b0; bus.x_valid = 1'b0; start = 1'b0;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("done_busy", busy, 0);
    if (b2b) begin
      start = 1'b1; cfg_simd = ~simd;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("res_cnt", nres - n0, nv);
    chk("last_cnt", nlast - l0, nv > 0);
    chk("sb_empty", q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.w_valid = 1'b0; bus.w_data = '0;
    bus.x_valid = 1'b0; bus.x_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    wset = '{16'd1, 16'd2, 16'd3, 16'd4};
    x_fix_en = 1; x_fix = 16'd5;
    run_job(0, 1, 0, 0, -1, 0, 0);
    chk("dot50", last_res, 32'd50);

    for (int i = 0; i < N_PE; i++) wset[i] = 16'($urandom);
    x_fix_en = 0;
    run_job(0, 3, 1, 1, -1, 0, 0);

    for (int i = 0; i < N_PE; i++) wset[i] = 16'h0102;
    x_fix_en = 1; x_fix = 16'h0304;
    run_job(1, 2, 1, 0, -1, 0, 0);
    chk("simd_dot", last_res, {16'd12, 16'd32});

    x_fix_en = 0;
    run_job(0, 0, 1, 0, -1, 1, 1);

    for (int i = 0; i < N_PE; i++) wset[i] = 16'($urandom);
    run_job(1, 6, 0, 0, 2, 0, 0);

    repeat (6) begin
      for (int i = 0; i < N_PE; i++) wset[i] = 16'($urandom);
      run_job(1'($urandom_range(0, 1)), $urandom_range(1, 8),
              1, 2, -1, 1'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
